// File: rtl/sender_pkg.sv
// Shared types and widths for the sender controller and its arbiter.
package sender_pkg;

  localparam int unsigned SENDER_WIDTH = 8;
  localparam int unsigned BIT_CNT_W    = $clog2(SENDER_WIDTH);
  localparam int unsigned DIV_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/sender_arb.sv
// Two-way arbiter issuing one-cycle registered grant pulses.
// SENDER_CTRL_RR_EN selects round-robin; otherwise req0 has fixed priority.
module sender_arb
  import sender_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic pick0_c;
  logic pick1_c;

`ifdef SENDER_CTRL_RR_EN
  // High when requester 1 held the most recent grant; reset favours requester 0.
  logic last1;

  always_comb begin
    pick0_c = en && req0 && (!req1 || last1);
    pick1_c = en && req1 && !pick0_c;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      last1 <= 1'b1;
    end else if (pick0_c) begin
      last1 <= 1'b0;
    end else if (pick1_c) begin
      last1 <= 1'b1;
    end
  end
`else
  always_comb begin
    pick0_c = en && req0;
    pick1_c = en && req1 && !req0;
  end
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
    end else begin
      gnt0 <= pick0_c;
      gnt1 <= pick1_c;
    end
  end

endmodule

// File: rtl/sender_ctrl.sv
// Sequences the sender shift register: grant, one load sclk period, eight shift periods, gap.
// Arbitration mode is set by SENDER_CTRL_RR_EN (see sender_arb).
module sender_ctrl
  import sender_pkg::*;
#(
  parameter int unsigned DIV   = 4,
  parameter int unsigned WIDTH = SENDER_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic [WIDTH-1:0] load_data,
  output logic             sh_ld,
  output logic             sclk,
  output logic             ss_n,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] LOAD  = ST_LOAD;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] GAP   = ST_GAP;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WIDTH - 1);

  logic [1:0]           state;
  logic [1:0]           state_d;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     div_d;
  logic [BIT_CNT_W-1:0] bit_q;
  logic [BIT_CNT_W-1:0] bit_d;
  logic [WIDTH-1:0]     load_data_d;
  logic                 sclk_d;
  logic                 sh_ld_d;
  logic                 ss_n_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 tick_c;
  logic                 arb_en_c;

  // Arbitration runs whenever the next cycle is IDLE, so held requests regrant straight after GAP.
  sender_arb u_arb (
    .clk   (clk),
    .clear (clear),
    .en    (arb_en_c),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state;
    div_d       = div_q;
    bit_d       = bit_q;
    sclk_d      = sclk;
    load_data_d = load_data;
    tick_c      = (div_q == DIV_LAST);

    case (state)
      IDLE: begin
        div_d  = '0;
        bit_d  = '0;
        sclk_d = 1'b0;
        if (gnt0 || gnt1) begin
          state_d     = LOAD;
          load_data_d = gnt0 ? data0 : data1;
        end
      end
      LOAD: begin
        div_d = tick_c ? '0 : div_q + DIV_W'(1);
        if (tick_c) begin
          sclk_d = ~sclk;
          if (sclk) begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        div_d = tick_c ? '0 : div_q + DIV_W'(1);
        if (tick_c) begin
          sclk_d = ~sclk;
          // Falling edge of sclk advances the bit count; the last one ends the shift phase.
          if (sclk) begin
            bit_d = bit_q + BIT_CNT_W'(1);
            if (bit_q == BIT_LAST) begin
              state_d = GAP;
            end
          end
        end
      end
      GAP: begin
        sclk_d = 1'b0;
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);
        if (tick_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    arb_en_c = (state_d == IDLE);
    ss_n_d   = !((state_d == LOAD) || (state_d == SHIFT));
    sh_ld_d  = (state_d != LOAD);
    busy_d   = (state_d != IDLE) || (arb_en_c && (req0 || req1));
    done_d   = (state_d == GAP) && (div_d == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      load_data <= '0;
      sh_ld     <= 1'b1;
      sclk      <= 1'b0;
      ss_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      load_data <= load_data_d;
      sh_ld     <= sh_ld_d;
      sclk      <= sclk_d;
      ss_n      <= ss_n_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
